// File: rtl/uart_matrix_frame_rx.sv
// UART receiver (8N1, or 8E1 with UART_PARITY_EN) feeding a header/N/matrix/vector/tail frame parser and payload buffer.
// Latency: byte_valid 1 cycle after stop sample; frame_valid 1 cycle after tail byte_valid; rd_data 1 cycle after rd_addr.
// Backpressure: none on the line; frame_valid holds until frame_ack, and bytes arriving meanwhile are dropped.
module uart_matrix_frame_rx #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         MAX_N        = 8,
    parameter logic [7:0] HDR_BYTE     = 8'hFE,
    parameter logic [7:0] TAIL_BYTE    = 8'hEF,
    localparam int        NW           = $clog2(MAX_N) + 1,
    localparam int        DEPTH        = MAX_N * MAX_N + MAX_N,
    localparam int        AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          serial_rx,
    output logic [7:0]    byte_data,
    output logic          byte_valid,
    output logic [NW-1:0] size_n,
    output logic          frame_valid,
    input  logic          frame_ack,
    output logic          frame_err,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_IDLE, P_SIZE, P_MATRIX, P_VECTOR, P_TAIL, P_DONE} p_state_t;

    rx_state_t         rx_state_q, rx_state_d;
    p_state_t          p_state_q, p_state_d;
    logic [2:0]        sync_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        byte_data_q, byte_data_d;
    logic              byte_valid_q, byte_valid_d;
    logic              frame_err_q, frame_err_d;
    logic [NW-1:0]     n_q, n_d, size_n_q, size_n_d;
    logic [2*NW-1:0]   k_q, k_d, nn;
    logic [NW-1:0]     j_q, j_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [7:0]        buf_mem [DEPTH];
    logic              rx_s, rx_fall, half_tick, bit_tick, stop_ok, line_err, parse_err, size_ok;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
`ifdef UART_PARITY_EN
    logic              par_ok_q, par_ok_d;
`endif

    // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detection
    assign rx_s      = sync_q[1];
    assign rx_fall   = sync_q[2] & ~sync_q[1];
    assign half_tick = (cnt_q == CW'(CLKS_PER_BIT / 2 - 1));
    assign bit_tick  = (cnt_q == CW'(CLKS_PER_BIT - 1));
`ifdef UART_PARITY_EN
    assign stop_ok   = rx_s & par_ok_q;
`else
    assign stop_ok   = rx_s;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q       <= 3'b111;
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            p_state_q    <= P_IDLE;
            n_q          <= '0;
            size_n_q     <= '0;
            k_q          <= '0;
            j_q          <= '0;
            rd_data_q    <= '0;
`ifdef UART_PARITY_EN
            par_ok_q     <= 1'b0;
`endif
        end else begin
            sync_q       <= {sync_q[1:0], serial_rx};
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            p_state_q    <= p_state_d;
            n_q          <= n_d;
            size_n_q     <= size_n_d;
            k_q          <= k_d;
            j_q          <= j_d;
            rd_data_q    <= rd_data_d;
`ifdef UART_PARITY_EN
            par_ok_q     <= par_ok_d;
`endif
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:   if (rx_fall) rx_state_d = RX_START;
            RX_START:  if (half_tick) rx_state_d = rx_s ? RX_IDLE : RX_DATA;
`ifdef UART_PARITY_EN
            RX_DATA:   if (bit_tick && bit_q == 3'd7) rx_state_d = RX_PARITY;
            RX_PARITY: if (bit_tick) rx_state_d = RX_STOP;
`else
            RX_DATA:   if (bit_tick && bit_q == 3'd7) rx_state_d = RX_STOP;
`endif
            RX_STOP:   if (bit_tick) rx_state_d = RX_IDLE;
            default:   rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = (rx_state_q == RX_IDLE) ? '0 : cnt_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        line_err     = 1'b0;
`ifdef UART_PARITY_EN
        par_ok_d     = par_ok_q;
`endif
        case (rx_state_q)
            RX_IDLE:  bit_d = '0;
            RX_START: if (half_tick) cnt_d = '0;
            RX_DATA: if (bit_tick) begin
                cnt_d   = '0;
                shift_d = {rx_s, shift_q[7:1]};
                bit_d   = bit_q + 1'b1;
            end
`ifdef UART_PARITY_EN
            RX_PARITY: if (bit_tick) begin
                cnt_d    = '0;
                par_ok_d = (rx_s == ^shift_q);
            end
`endif
            RX_STOP: if (bit_tick) begin
                cnt_d = '0;
                if (stop_ok) begin
                    byte_valid_d = 1'b1;
                    byte_data_d  = shift_q;
                end else begin
                    line_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign nn      = {{NW{1'b0}}, n_q} * {{NW{1'b0}}, n_q};
    assign size_ok = (int'(byte_data_q) >= 1) && (int'(byte_data_q) <= MAX_N);

    // A pending frame_err (line or parse) always returns the parser to IDLE
    always_comb begin
        p_state_d = p_state_q;
        if (frame_err_q) begin
            p_state_d = P_IDLE;
        end else begin
            case (p_state_q)
                P_IDLE:   if (byte_valid_q && byte_data_q == HDR_BYTE) p_state_d = P_SIZE;
                P_SIZE:   if (byte_valid_q) p_state_d = size_ok ? P_MATRIX : P_IDLE;
                P_MATRIX: if (byte_valid_q && k_q == nn - 1'b1) p_state_d = P_VECTOR;
                P_VECTOR: if (byte_valid_q && j_q == n_q - 1'b1) p_state_d = P_TAIL;
                P_TAIL:   if (byte_valid_q) p_state_d = (byte_data_q == TAIL_BYTE) ? P_DONE : P_IDLE;
                P_DONE:   if (frame_ack) p_state_d = P_IDLE;
                default:  p_state_d = P_IDLE;
            endcase
        end
    end

    always_comb begin
        n_d       = n_q;
        k_d       = k_q;
        j_d       = j_q;
        size_n_d  = size_n_q;
        wr_en     = 1'b0;
        wr_addr   = '0;
        parse_err = 1'b0;
        if (!frame_err_q && byte_valid_q) begin
            case (p_state_q)
                P_SIZE: begin
                    if (size_ok) begin
                        n_d = NW'(byte_data_q);
                        k_d = '0;
                        j_d = '0;
                    end else begin
                        parse_err = 1'b1;
                    end
                end
                P_MATRIX: begin
                    wr_en   = 1'b1;
                    wr_addr = AW'(k_q);
                    k_d     = k_q + 1'b1;
                end
                P_VECTOR: begin
                    wr_en   = 1'b1;
                    wr_addr = AW'(MAX_N * MAX_N) + AW'(j_q);
                    j_d     = j_q + 1'b1;
                end
                P_TAIL: begin
                    if (byte_data_q == TAIL_BYTE) size_n_d = n_q;
                    else                          parse_err = 1'b1;
                end
                default: ;
            endcase
        end
        frame_err_d = line_err | parse_err;
    end

    always_ff @(posedge clk) begin
        if (wr_en) buf_mem[wr_addr] <= byte_data_q;
    end

    always_comb begin
        rd_data_d = '0;
        if ({1'b0, rd_addr} < (AW + 1)'(DEPTH)) rd_data_d = buf_mem[rd_addr];
    end

    assign byte_data   = byte_data_q;
    assign byte_valid  = byte_valid_q;
    assign size_n      = size_n_q;
    assign frame_valid = (p_state_q == P_DONE);
    assign frame_err   = frame_err_q;
    assign rd_data     = rd_data_q;
endmodule

// File: tb/tb_uart_matrix_frame_rx.sv
// Bench for uart_matrix_frame_rx: bytes expected on byte_valid are queued as they are sent and checked in order.
module tb_uart_matrix_frame_rx;
    localparam int CPB   = 16;
    localparam int MAX_N = 8;
    localparam int NW    = 4;
    localparam int AW    = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          serial_rx = 1'b1;
    logic          frame_ack = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic [NW-1:0] size_n;
    logic          frame_valid;
    logic          frame_err;
    logic [7:0]    rd_data;

    int            errors = 0;
    int            checks = 0;
    int            bv_cnt = 0;
    int            err_cnt = 0;
    logic [7:0]    exp_q[$];
    logic [7:0]    mon_exp;
`ifdef UART_PARITY_EN
    logic          par_flip = 1'b0;
`endif

    uart_matrix_frame_rx #(.CLKS_PER_BIT(CPB), .MAX_N(MAX_N)) dut (
        .clk(clk), .reset(reset), .serial_rx(serial_rx),
        .byte_data(byte_data), .byte_valid(byte_valid), .size_n(size_n),
        .frame_valid(frame_valid), .frame_ack(frame_ack), .frame_err(frame_err),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_valid) begin
            bv_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte got=%02h want=none", byte_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (byte_data !== mon_exp) begin
                    errors++;
                    $display("FAIL byte_data got=%02h want=%02h", byte_data, mon_exp);
                end
            end
        end
        if (frame_err) err_cnt++;
    end

    task automatic send_byte(input logic [7:0] d, input logic stop_b, input logic expect_ok);
        if (expect_ok) exp_q.push_back(d);
        @(negedge clk);
        serial_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_rx = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        serial_rx = (^d) ^ par_flip;
        repeat (CPB) @(negedge clk);
`endif
        serial_rx = stop_b;
        repeat (CPB) @(negedge clk);
        serial_rx = 1'b1;
    endtask

    task automatic sb(input logic [7:0] d);
        send_byte(d, 1'b1, 1'b1);
    endtask

    task automatic read_chk(input logic [AW-1:0] a, input logic [7:0] want);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        checks++;
        if (rd_data !== want) begin
            errors++;
            $display("FAIL rd_data[%0d] got=%02h want=%02h", a, rd_data, want);
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        checks++;
        if (frame_valid !== 1'b1) begin
            errors++;
            $display("FAIL fv_before_ack got=%0b want=1", frame_valid);
        end
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL fv_after_ack got=%0b want=0", frame_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({byte_data, byte_valid, size_n, frame_valid, frame_err, rd_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%02h/%0b/%0d/%0b/%0b/%02h want=all zero",
                     byte_data, byte_valid, size_n, frame_valid, frame_err, rd_data);
        end
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_valid_frame();
        int bv0;
        bv0 = bv_cnt;
        sb(8'hFE);
        sb(8'h02);
        for (int i = 1; i <= 6; i++) sb(8'(i));
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL fv_before_tail got=%0b want=0", frame_valid);
        end
        sb(8'hEF);
        repeat (4) @(negedge clk);
        checks++;
        if (bv_cnt - bv0 != 9) begin
            errors++;
            $display("FAIL bv_count got=%0d want=9", bv_cnt - bv0);
        end
        checks++;
        if (frame_valid !== 1'b1 || size_n !== 4'd2) begin
            errors++;
            $display("FAIL frame_n2 got=fv%0b n%0d want=fv1 n2", frame_valid, size_n);
        end
        for (int i = 0; i < 4; i++) read_chk(AW'(i), 8'(i + 1));
        read_chk(7'd64, 8'h05);
        read_chk(7'd65, 8'h06);
        read_chk(7'd72, 8'h00);
        read_chk(7'd127, 8'h00);
        do_ack();
    endtask

    task automatic test_bad_size();
        int e0;
        e0 = err_cnt;
        sb(8'hFE);
        sb(8'h00);
        repeat (4) @(negedge clk);
        checks++;
        if (err_cnt - e0 != 1) begin
            errors++;
            $display("FAIL size_zero_err got=%0d want=1", err_cnt - e0);
        end
        sb(8'hFE);
        sb(8'h09);
        repeat (4) @(negedge clk);
        checks++;
        if (err_cnt - e0 != 2 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL size_nine_err got=err%0d fv%0b want=err2 fv0", err_cnt - e0, frame_valid);
        end
    endtask

    task automatic test_bad_tail_and_ack();
        int e0;
        e0 = err_cnt;
        sb(8'hFE); sb(8'h01); sb(8'hAA); sb(8'hBB); sb(8'h55);
        repeat (4) @(negedge clk);
        checks++;
        if (err_cnt - e0 != 1 || frame_valid !== 1'b0 || size_n !== 4'd2) begin
            errors++;
            $display("FAIL bad_tail got=err%0d fv%0b n%0d want=err1 fv0 n2", err_cnt - e0, frame_valid, size_n);
        end
        sb(8'hFE); sb(8'h01); sb(8'h7E); sb(8'h81); sb(8'hEF);
        repeat (4) @(negedge clk);
        checks++;
        if (frame_valid !== 1'b1 || size_n !== 4'd1) begin
            errors++;
            $display("FAIL frame_n1 got=fv%0b n%0d want=fv1 n1", frame_valid, size_n);
        end
        read_chk(7'd0, 8'h7E);
        read_chk(7'd64, 8'h81);
        sb(8'hFE);
        repeat (4) @(negedge clk);
        checks++;
        if (err_cnt - e0 != 1 || frame_valid !== 1'b1 || size_n !== 4'd1) begin
            errors++;
            $display("FAIL hdr_in_done got=err%0d fv%0b n%0d want=err1 fv1 n1", err_cnt - e0, frame_valid, size_n);
        end
        do_ack();
    endtask

    task automatic test_line_errors();
        int e0;
        int b0;
        sb(8'hFE); sb(8'h02); sb(8'h11); sb(8'h22);
        e0 = err_cnt;
        b0 = bv_cnt;
        send_byte(8'h3C, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (err_cnt - e0 != 1 || bv_cnt != b0) begin
            errors++;
            $display("FAIL stop_err got=err%0d bv%0d want=err1 bv0", err_cnt - e0, bv_cnt - b0);
        end
        sb(8'h33); sb(8'h44); sb(8'h55); sb(8'h66); sb(8'hEF);
        repeat (4) @(negedge clk);
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL parser_not_idle got=fv%0b want=fv0", frame_valid);
        end
        e0 = err_cnt;
        b0 = bv_cnt;
        @(negedge clk);
        serial_rx = 1'b0;
        repeat (3) @(negedge clk);
        serial_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checks++;
        if (err_cnt != e0 || bv_cnt != b0) begin
            errors++;
            $display("FAIL glitch got=err%0d bv%0d want=err0 bv0", err_cnt - e0, bv_cnt - b0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int e0;
        sb(8'hFE); sb(8'h03);
        for (int i = 0; i < 9; i++) sb(8'h90 + 8'(i));
        sb(8'hA0);
        e0 = err_cnt;
        @(negedge clk);
        serial_rx = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({byte_data, byte_valid, size_n, frame_valid, frame_err, rd_data} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got=%02h/%0b/%0d/%0b/%0b/%02h want=all zero",
                     byte_data, byte_valid, size_n, frame_valid, frame_err, rd_data);
        end
        serial_rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        sb(8'hFE); sb(8'h03);
        for (int i = 0; i < 9; i++) sb(8'h20 + 8'(i));
        for (int i = 0; i < 3; i++) sb(8'h40 + 8'(i));
        sb(8'hEF);
        repeat (4) @(negedge clk);
        checks++;
        if (frame_valid !== 1'b1 || size_n !== 4'd3 || err_cnt != e0) begin
            errors++;
            $display("FAIL frame_after_reset got=fv%0b n%0d err%0d want=fv1 n3 err0", frame_valid, size_n, err_cnt - e0);
        end
        read_chk(7'd8, 8'h28);
        read_chk(7'd66, 8'h42);
        do_ack();
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        int e0;
        int b0;
        e0 = err_cnt;
        b0 = bv_cnt;
        par_flip = 1'b1;
        send_byte(8'h07, 1'b1, 1'b0);
        par_flip = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (err_cnt - e0 != 1 || bv_cnt != b0) begin
            errors++;
            $display("FAIL parity_err got=err%0d bv%0d want=err1 bv0", err_cnt - e0, bv_cnt - b0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_valid_frame();
        test_bad_size();
        test_bad_tail_and_ack();
        test_line_errors();
        test_reset_mid_frame();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_bytes got=%0d pending want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_matrix_frame_rx.md
Name: uart_matrix_frame_rx

Overview:
- Parametrised UART receiver plus frame parser for the matrix/vector processor path.
- Oversamples serial_rx and assembles bytes, then parses a framed packet: header, size N, N×N matrix, N-element vector, tail.
- Stores the payload in an internal buffer and exposes it through a registered read port with a valid/ack handshake.
- Replaces the fixed-size receive/control/storage chain and feeds the processor top.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); minimum 4.
- MAX_N, 8, largest accepted matrix dimension; buffer holds MAX_N*MAX_N + MAX_N bytes.
- HDR_BYTE, 8'hFE, frame header value.
- TAIL_BYTE, 8'hEF, frame tail value.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- serial_rx  in  1  UART line, idle high, asynchronous to clk.
- byte_data  out  8  last received byte.
- byte_valid  out  1  one-cycle pulse per good byte.
- size_n  out  $clog2(MAX_N)+1  N of the last accepted frame.
- frame_valid  out  1  complete frame stored; held until frame_ack.
- frame_ack  in  1  consumer release; sampled only while frame_valid=1.
- frame_err  out  1  one-cycle pulse on any protocol or line error.
- rd_addr  in  $clog2(MAX_N*MAX_N+MAX_N)  buffer read address.
- rd_data  out  8  buffer[rd_addr], registered, 1-cycle latency.

Behaviour:
- Reset: all outputs 0, parser IDLE, RX idle; buffer contents not reset.
- RX front end:
  - serial_rx passes through a 2-FF synchroniser.
  - A falling edge in RX idle starts a bit counter; the start bit is re-sampled at CLKS_PER_BIT/2.
  - If the start bit is high at that sample, it is a glitch: return to idle with no error.
  - 8 data bits are sampled LSB first at each subsequent bit centre.
- Stop bit:
  - Stop=1: byte_data updates and byte_valid pulses on the cycle after the stop sample.
  - Stop=0: the byte is discarded, frame_err pulses, and the parser is forced to IDLE.
  - RX returns to idle after the stop sample; back-to-back frames are supported.
- Parser states: IDLE, SIZE, MATRIX, VECTOR, TAIL, DONE. Only good bytes advance it.
  - IDLE: HDR_BYTE -> SIZE. Any other byte is ignored silently.
  - SIZE: 1 <= byte <= MAX_N -> latch N internally, clear index k, go to MATRIX. Otherwise frame_err pulse, -> IDLE.
  - MATRIX: buffer[k] <= byte (row-major). When k == N*N-1 -> VECTOR with j=0.
  - VECTOR: buffer[MAX_N*MAX_N + j] <= byte. When j == N-1 -> TAIL.
  - TAIL: byte == TAIL_BYTE -> DONE; size_n <= N and frame_valid=1 on the cycle after that byte_valid. Otherwise frame_err pulse, -> IDLE, frame_valid stays 0.
  - DONE: incoming bytes still produce byte_valid but are dropped by the parser, with no error. frame_ack=1 -> IDLE; frame_valid=0 next cycle.
- Header bytes:
  - HDR_BYTE received in SIZE/MATRIX/VECTOR/TAIL is treated as data or tail, with no resync.
  - Corrupt frames are recovered via the error paths above.
- Storage and read port:
  - N*N is computed at width 2*($clog2(MAX_N)+1); no overflow for N <= MAX_N.
  - Buffer is written only in MATRIX/VECTOR.
  - size_n changes only on a DONE entry, so the previous frame's size stays valid during reception.
  - rd_addr out of range returns 0.
  - Reads during reception are allowed; in-flight locations return partial data.
- Simultaneous events: a byte_valid in the same cycle as frame_ack in DONE is dropped; the parser still goes to IDLE.
- Async reset mid-byte or mid-frame aborts everything immediately; no frame_err is produced.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: the frame is 8E1. An even-parity bit is sampled after bit 7, before the stop bit. A parity mismatch discards the byte, pulses frame_err (same cycle position as a stop error) and forces the parser to IDLE.
- Undefined: the frame is 8N1 and there is no parity logic.

Test Plan:
- Valid frame, N=2 (CLKS_PER_BIT=16, MAX_N=8):
  - Stimulus: send FE 02 01 02 03 04 05 06 EF.
  - Response: 9 byte_valid pulses; frame_valid=1, size_n=2.
  - Reads: rd_addr 0..3 -> 01,02,03,04; rd_addr 64,65 -> 05,06.
- Bad size: send FE 00 and FE 09 -> frame_err pulse each; frame_valid stays 0; the next valid frame is accepted.
- Bad tail, then ack behaviour:
  - Send FE 01 AA BB 55 -> frame_err on the 55 byte, frame_valid=0.
  - Then send a valid N=1 frame -> frame_valid=1.
  - Send FE while in DONE -> ignored.
  - frame_ack -> frame_valid=0 next cycle.
- Line errors:
  - Stop bit forced 0 on byte 0x3C mid-matrix -> no byte_valid, frame_err pulse, parser IDLE.
  - 3-cycle low glitch on idle line -> no byte_valid, no frame_err.
- Reset and parity:
  - Assert reset mid-vector -> all outputs 0; the next full frame parses correctly.
  - With UART_PARITY_EN: byte 0x07 sent with parity bit 0 -> frame_err pulse.
